// File: rtl/freq_hop_ctrl.sv
// Frequency-word controller for the down-conversion NCO: writable tuning table,
// manual or auto-hop selection, and rate-limited slewing of the output word.
module freq_hop_ctrl #(
  parameter int FREQ_W  = 32,
  parameter int ADDR_W  = 3,
  parameter int STEP_W  = 24,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [FREQ_W-1:0]  cfg_data,
  input  logic               mode,
  input  logic [ADDR_W-1:0]  word,
  input  logic [STEP_W-1:0]  step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [ADDR_W-1:0]  hop_last,
  output logic [FREQ_W-1:0]  freq,
  output logic               settled,
  output logic               hop,
  output logic [ADDR_W-1:0]  hop_idx
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_MAN   = 2'd0,
    S_SLEW  = 2'd1,
    S_DWELL = 2'd2
  } state_t;

  function automatic logic [FREQ_W-1:0] default_word(input int idx);
    logic [FREQ_W-1:0] base;
    base = FREQ_W'(10 + idx);
    return base << (FREQ_W - 8);
  endfunction

  logic [FREQ_W-1:0]  table_r [DEPTH];
  logic [FREQ_W-1:0]  freq_r;
  logic [FREQ_W-1:0]  target_r;
  logic [ADDR_W-1:0]  hop_idx_r;
  logic [DWELL_W-1:0] dwell_cnt_r;
  logic               hop_r;
  state_t             state_r;

  logic [ADDR_W-1:0]  sel_s;
  logic [FREQ_W:0]    diff_s;
  logic [FREQ_W:0]    abs_diff_s;
  logic [FREQ_W:0]    step_ext_s;
  logic [FREQ_W-1:0]  step_fw_s;
  logic [FREQ_W-1:0]  freq_nx_s;
  logic               settled_s;
  logic [DWELL_W-1:0] dwell_lim_s;
  state_t             state_nx_s;
  logic [ADDR_W-1:0]  hop_idx_nx_s;
  logic [DWELL_W-1:0] dwell_cnt_nx_s;
  logic               hop_nx_s;

  assign freq    = freq_r;
  assign settled = settled_s;
  assign hop     = hop_r;
  assign hop_idx = hop_idx_r;

  // Tuning table: reset reloads defaults, writes ignore en.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_r[i] <= default_word(i);
      end
    end else if (cfg_we) begin
      table_r[cfg_addr] <= cfg_data;
    end
  end

  // Slew datapath: difference is taken one bit wider so it can never overflow.
  always_comb begin
    sel_s      = mode ? hop_idx_r : word;
    settled_s  = (freq_r == target_r);
    diff_s     = {target_r[FREQ_W-1], target_r} - {freq_r[FREQ_W-1], freq_r};
    abs_diff_s = diff_s[FREQ_W] ? (~diff_s + {{FREQ_W{1'b0}}, 1'b1}) : diff_s;
    step_ext_s = {{(FREQ_W + 1 - STEP_W){1'b0}}, step};
    step_fw_s  = {{(FREQ_W - STEP_W){1'b0}}, step};
    freq_nx_s  = freq_r;
    if ((step == {STEP_W{1'b0}}) || (abs_diff_s <= step_ext_s)) begin
      freq_nx_s = target_r;
    end else if (diff_s[FREQ_W]) begin
      freq_nx_s = freq_r - step_fw_s;
    end else begin
      freq_nx_s = freq_r + step_fw_s;
    end
  end

  // Hop sequencer next-state; the table compare hides the stale target right after a hop.
  always_comb begin
    state_nx_s     = state_r;
    hop_idx_nx_s   = hop_idx_r;
    dwell_cnt_nx_s = dwell_cnt_r;
    hop_nx_s       = 1'b0;
    dwell_lim_s    = (dwell == {DWELL_W{1'b0}}) ? {DWELL_W{1'b0}} : (dwell - DWELL_W'(1));
    if (!mode) begin
      state_nx_s = S_MAN;
    end else begin
      case (state_r)
        S_MAN: begin
          state_nx_s   = S_SLEW;
          hop_idx_nx_s = {ADDR_W{1'b0}};
        end
        S_SLEW: begin
          if (settled_s && (target_r == table_r[hop_idx_r])) begin
            state_nx_s     = S_DWELL;
            dwell_cnt_nx_s = {DWELL_W{1'b0}};
          end else begin
            state_nx_s = S_SLEW;
          end
        end
        S_DWELL: begin
          if (dwell_cnt_r == dwell_lim_s) begin
            hop_idx_nx_s = (hop_idx_r >= hop_last) ? {ADDR_W{1'b0}} : (hop_idx_r + ADDR_W'(1));
            hop_nx_s     = 1'b1;
            state_nx_s   = S_SLEW;
          end else begin
            dwell_cnt_nx_s = dwell_cnt_r + DWELL_W'(1);
          end
        end
        default: begin
          state_nx_s = S_MAN;
        end
      endcase
    end
  end

  // State registers: everything holds while en is low, hop pulse is forced off.
  always_ff @(posedge clk) begin
    if (rst) begin
      freq_r      <= {FREQ_W{1'b0}};
      target_r    <= {FREQ_W{1'b0}};
      hop_idx_r   <= {ADDR_W{1'b0}};
      dwell_cnt_r <= {DWELL_W{1'b0}};
      hop_r       <= 1'b0;
      state_r     <= S_MAN;
    end else if (en) begin
      freq_r      <= freq_nx_s;
      target_r    <= table_r[sel_s];
      hop_idx_r   <= hop_idx_nx_s;
      dwell_cnt_r <= dwell_cnt_nx_s;
      hop_r       <= hop_nx_s;
      state_r     <= state_nx_s;
    end else begin
      hop_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_freq_hop_ctrl.sv
// Directed self-checking bench for freq_hop_ctrl with default parameters.
module tb_freq_hop_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        mode;
  logic [2:0]  word;
  logic [23:0] step;
  logic [15:0] dwell;
  logic [2:0]  hop_last;
  logic [31:0] freq;
  logic        settled;
  logic        hop;
  logic [2:0]  hop_idx;

  int total = 0;
  int bad   = 0;

  freq_hop_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .mode(mode), .word(word), .step(step), .dwell(dwell),
    .hop_last(hop_last), .freq(freq), .settled(settled), .hop(hop), .hop_idx(hop_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; cfg_we = 1'b0; mode = 1'b0; word = 3'd0;
    step = 24'd0; dwell = 16'd0; hop_last = 3'd0;
    tick();
    rst = 1'b0;
  endtask

  task automatic settle_manual(input logic [2:0] w);
    mode = 1'b0; step = 24'd0; word = w;
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (freq !== 32'h0) begin bad++; $display("FAIL reset_freq got=%h exp=%h", freq, 32'h0); end
    total++; if (settled !== 1'b1) begin bad++; $display("FAIL reset_settled got=%b exp=1", settled); end
    total++; if (hop !== 1'b0) begin bad++; $display("FAIL reset_hop got=%b exp=0", hop); end
    total++; if (hop_idx !== 3'd0) begin bad++; $display("FAIL reset_hop_idx got=%0d exp=0", hop_idx); end
  endtask

  task automatic test_manual_sweep();
    logic [31:0] prev;
    logic [31:0] exp;
    do_reset();
    prev = 32'h0;
    for (int w = 0; w < 8; w++) begin
      exp  = 32'(10 + w) << 24;
      word = 3'(w);
      tick();
      total++; if (freq !== prev) begin bad++; $display("FAIL manual_lat1 w=%0d got=%h exp=%h", w, freq, prev); end
      tick();
      total++; if (freq !== exp) begin bad++; $display("FAIL manual_freq w=%0d got=%h exp=%h", w, freq, exp); end
      total++; if (settled !== 1'b1) begin bad++; $display("FAIL manual_settled w=%0d got=%b exp=1", w, settled); end
      prev = exp;
    end
  endtask

  task automatic test_slew();
    logic [31:0] up [4];
    logic [31:0] dn [4];
    up = '{32'h0a400000, 32'h0a800000, 32'h0ac00000, 32'h0b000000};
    dn = '{32'h0ac00000, 32'h0a800000, 32'h0a400000, 32'h0a000000};
    do_reset();
    settle_manual(3'd0);
    step = 24'h400000;
    word = 3'd1;
    tick();
    total++; if (settled !== 1'b0) begin bad++; $display("FAIL slew_up_start_settled got=%b exp=0", settled); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (freq !== up[i]) begin bad++; $display("FAIL slew_up i=%0d got=%h exp=%h", i, freq, up[i]); end
      total++; if (settled !== (i == 3)) begin bad++; $display("FAIL slew_up_settled i=%0d got=%b exp=%b", i, settled, (i == 3)); end
    end
    word = 3'd0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (freq !== dn[i]) begin bad++; $display("FAIL slew_dn i=%0d got=%h exp=%h", i, freq, dn[i]); end
    end
  endtask

  task automatic test_clamp();
    logic [31:0] seq [6];
    seq = '{32'h0a300000, 32'h0a600000, 32'h0a900000, 32'h0ac00000, 32'h0af00000, 32'h0b000000};
    do_reset();
    settle_manual(3'd0);
    step = 24'h300000;
    word = 3'd1;
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (freq !== seq[i]) begin bad++; $display("FAIL clamp i=%0d got=%h exp=%h", i, freq, seq[i]); end
    end
    tick();
    total++; if (freq !== 32'h0b000000) begin bad++; $display("FAIL clamp_hold got=%h exp=0b000000", freq); end
  endtask

  task automatic test_table_write();
    logic [31:0] seq [6];
    seq = '{32'hf8000000, 32'hf9000000, 32'hf8000000, 32'hf7000000, 32'hf6000000, 32'hf6000000};
    do_reset();
    settle_manual(3'd2);
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 32'hf6000000;
    tick();
    cfg_we = 1'b0;
    total++; if (freq !== 32'h0c000000) begin bad++; $display("FAIL wr_old got=%h exp=0c000000", freq); end
    tick();
    total++; if (freq !== 32'h0c000000) begin bad++; $display("FAIL wr_lat got=%h exp=0c000000", freq); end
    tick();
    total++; if (freq !== 32'hf6000000) begin bad++; $display("FAIL wr_new got=%h exp=f6000000", freq); end
    // ramp up toward 0x0c000000, then retarget back down mid-ramp
    step = 24'h000000;
    step = 24'hffffff;
    step = 24'h000000;
    cfg_we = 1'b1; cfg_data = 32'h0c000000;
    tick();
    cfg_we = 1'b0;
    step = 24'h000000;
    tick();
    total++; if (freq !== 32'hf6000000) begin bad++; $display("FAIL ramp_start got=%h exp=f6000000", freq); end
    do_ramp_retarget(seq);
  endtask

  task automatic do_ramp_retarget(input logic [31:0] seq [6]);
    step = 24'h000000;
    // step of 0x01000000 does not fit 24 bits, so use the largest multiple-friendly value via table spacing
    step = 24'h800000;
    tick();
    total++; if (freq !== 32'hf6800000) begin bad++; $display("FAIL ramp_up0 got=%h exp=f6800000", freq); end
    tick();
    total++; if (freq !== 32'hf7000000) begin bad++; $display("FAIL ramp_up1 got=%h exp=f7000000", freq); end
    cfg_we = 1'b1; cfg_data = 32'hf6000000;
    tick();
    cfg_we = 1'b0;
    total++; if (freq !== 32'hf7800000) begin bad++; $display("FAIL ramp_up2 got=%h exp=f7800000", freq); end
    tick();
    total++; if (freq !== seq[0]) begin bad++; $display("FAIL ramp_peak got=%h exp=%h", freq, seq[0]); end
    tick();
    total++; if (freq !== 32'hf7800000) begin bad++; $display("FAIL ramp_dn0 got=%h exp=f7800000", freq); end
    tick();
    total++; if (freq !== 32'hf7000000) begin bad++; $display("FAIL ramp_dn1 got=%h exp=f7000000", freq); end
    tick();
    total++; if (freq !== 32'hf6800000) begin bad++; $display("FAIL ramp_dn2 got=%h exp=f6800000", freq); end
    tick();
    total++; if (freq !== 32'hf6000000) begin bad++; $display("FAIL ramp_clamp got=%h exp=f6000000", freq); end
    tick();
    total++; if (freq !== 32'hf6000000 || settled !== 1'b1) begin bad++; $display("FAIL ramp_hold got=%h/%b exp=f6000000/1", freq, settled); end
  endtask

  task automatic test_auto_hop(input int dw, input int ncyc);
    int d, f, p, nh, nf;
    logic        exp_hop;
    logic [2:0]  exp_idx;
    logic [31:0] exp_freq;
    d = (dw == 0) ? 1 : dw;
    f = 1 + d;
    p = d + 3;
    do_reset();
    settle_manual(3'd0);
    dwell = 16'(dw); hop_last = 3'd2; mode = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      tick();
      exp_hop  = (k >= f) && (((k - f) % p) == 0);
      nh       = (k >= f) ? ((k - f) / p + 1) : 0;
      nf       = (k >= f + 2) ? ((k - f - 2) / p + 1) : 0;
      exp_idx  = 3'(nh % 3);
      exp_freq = 32'(10 + (nf % 3)) << 24;
      total++; if (hop !== exp_hop) begin bad++; $display("FAIL hop_pulse dw=%0d k=%0d got=%b exp=%b", dw, k, hop, exp_hop); end
      total++; if (hop_idx !== exp_idx) begin bad++; $display("FAIL hop_idx dw=%0d k=%0d got=%0d exp=%0d", dw, k, hop_idx, exp_idx); end
      total++; if (freq !== exp_freq) begin bad++; $display("FAIL hop_freq dw=%0d k=%0d got=%h exp=%h", dw, k, freq, exp_freq); end
    end
  endtask

  task automatic test_en_freeze();
    do_reset();
    settle_manual(3'd0);
    step = 24'h400000; word = 3'd1;
    tick();
    tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (freq !== 32'h0a400000) begin bad++; $display("FAIL freeze_freq i=%0d got=%h exp=0a400000", i, freq); end
    end
    en = 1'b1;
    tick();
    total++; if (freq !== 32'h0a800000) begin bad++; $display("FAIL resume0 got=%h exp=0a800000", freq); end
    tick();
    total++; if (freq !== 32'h0ac00000) begin bad++; $display("FAIL resume1 got=%h exp=0ac00000", freq); end
    // freeze mid-dwell: the hop must come exactly two en edges after resuming
    do_reset();
    settle_manual(3'd0);
    dwell = 16'd3; hop_last = 3'd2; mode = 1'b1;
    tick(); tick(); tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (hop !== 1'b0 || hop_idx !== 3'd0) begin bad++; $display("FAIL freeze_dwell i=%0d got=%b/%0d exp=0/0", i, hop, hop_idx); end
    end
    en = 1'b1;
    tick();
    total++; if (hop !== 1'b0) begin bad++; $display("FAIL dwell_resume0 got=%b exp=0", hop); end
    tick();
    total++; if (hop !== 1'b1 || hop_idx !== 3'd1) begin bad++; $display("FAIL dwell_resume1 got=%b/%0d exp=1/1", hop, hop_idx); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    settle_manual(3'd0);
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 32'h12345678;
    tick();
    cfg_we = 1'b0;
    step = 24'h100000; word = 3'd2;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (freq !== 32'h0 || settled !== 1'b1 || hop_idx !== 3'd0) begin bad++; $display("FAIL rst_mid got=%h/%b/%0d exp=0/1/0", freq, settled, hop_idx); end
    step = 24'd0;
    tick(); tick();
    total++; if (freq !== 32'h0c000000) begin bad++; $display("FAIL rst_table got=%h exp=0c000000", freq); end
  endtask

  initial begin
    cfg_addr = 3'd0; cfg_data = 32'h0;
    test_reset();
    test_manual_sweep();
    test_slew();
    test_clamp();
    test_table_write();
    test_auto_hop(3, 26);
    test_auto_hop(0, 14);
    test_en_freeze();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
